// File: rtl/serial_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_pattern_pkg
// Description : Shared state encoding and default sizing for serial_pattern_tx.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_pattern_pkg;

  localparam int c_pat_w = 4;
  localparam int c_rep_w = 8;
  localparam int c_gap_w = 4;
  localparam logic [c_pat_w-1:0] c_def_pat = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pattern_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : pattern_shift_reg
// Description : MSB-first pattern shifter with registered serial bit,
//               bit-index counter and last-bit flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_shift_reg #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic             i_clear,
  input  logic [PAT_W-1:0] i_data,
  output logic             o_msb,
  output logic             o_last
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] c_idx_top = IDX_W'(PAT_W - 1);

  // r_data holds the bits still to be sent after the one currently on r_bit
  logic [PAT_W-1:0] r_data;
  logic [IDX_W-1:0] r_idx;
  logic             r_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
      r_idx  <= '0;
      r_bit  <= 1'b0;
    end else if (i_load) begin
      r_bit  <= i_data[PAT_W-1];
      r_data <= {i_data[PAT_W-2:0], 1'b0};
      r_idx  <= c_idx_top;
    end else if (i_shift) begin
      r_bit  <= r_data[PAT_W-1];
      r_data <= {r_data[PAT_W-2:0], 1'b0};
      r_idx  <= r_idx - IDX_W'(1);
    end else if (i_clear) begin
      r_bit  <= 1'b0;
    end
  end

  assign o_msb  = r_bit;
  assign o_last = (r_idx == '0);

endmodule
`default_nettype wire

// File: rtl/serial_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_pattern_tx
// Description : Repeating MSB-first serial pattern generator with idle gaps.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_pattern_tx
  import serial_pattern_pkg::*;
#(
  parameter int               PAT_W   = c_pat_w,
  parameter logic [PAT_W-1:0] DEF_PAT = c_def_pat,
  parameter int               REP_W   = c_rep_w,
  parameter int               GAP_W   = c_gap_w
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             use_default,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [REP_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap_cnt,
  output logic             ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             done
);

  state_t           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [REP_W-1:0] r_rep;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] r_gap_left;
  logic             r_ready;
  logic             r_valid;
  logic             r_done;

  logic [PAT_W-1:0] w_sel_pat;
  logic [PAT_W-1:0] w_load_data;
  logic             w_load;
  logic             w_shift;
  logic             w_clear;
  logic             w_last;
  logic             w_bit;

  always_comb begin
    w_sel_pat   = use_default ? DEF_PAT : pattern_in;
    w_load_data = r_pat;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && rep_cnt != '0) begin
          w_load      = 1'b1;
          w_load_data = w_sel_pat;
        end
      end
      S_SHIFT: begin
        if (!w_last)
          w_shift = 1'b1;
        else if (r_rep != REP_W'(1) && r_gap == '0)
          w_load = 1'b1;
        else
          w_clear = 1'b1;
      end
      S_GAP: begin
        if (r_gap_left == '0)
          w_load = 1'b1;
      end
      default: ;
    endcase
  end

  pattern_shift_reg #(
    .PAT_W (PAT_W)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_clear (w_clear),
    .i_data  (w_load_data),
    .o_msb   (w_bit),
    .o_last  (w_last)
  );

  // r_rep counts repetitions still owed, including the one being shifted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_pat      <= '0;
      r_rep      <= '0;
      r_gap      <= '0;
      r_gap_left <= '0;
      r_ready    <= 1'b1;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ready <= 1'b0;
            r_pat   <= w_sel_pat;
            r_rep   <= rep_cnt;
            r_gap   <= gap_cnt;
            if (rep_cnt == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_SHIFT;
              r_valid <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          if (w_last) begin
            if (r_rep == REP_W'(1)) begin
              r_rep   <= '0;
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_rep <= r_rep - REP_W'(1);
              if (r_gap != '0) begin
                r_state    <= S_GAP;
                r_valid    <= 1'b0;
                r_gap_left <= r_gap - GAP_W'(1);
              end
            end
          end
        end
        S_GAP: begin
          if (r_gap_left == '0) begin
            r_state <= S_SHIFT;
            r_valid <= 1'b1;
          end else begin
            r_gap_left <= r_gap_left - GAP_W'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready     = r_ready;
  assign out_bit   = w_bit;
  assign out_valid = r_valid;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_pattern_tx
// Description : Self-checking bench for serial_pattern_tx against a stream model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_pattern_tx;

  logic       clk;
  logic       rst;
  logic       start;
  logic       use_default;
  logic [3:0] pattern_in;
  logic [7:0] rep_cnt;
  logic [3:0] gap_cnt;
  logic       ready;
  logic       out_bit;
  logic       out_valid;
  logic       done;

  int n_tests;
  int n_fail;

  serial_pattern_tx dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .use_default (use_default),
    .pattern_in  (pattern_in),
    .rep_cnt     (rep_cnt),
    .gap_cnt     (gap_cnt),
    .ready       (ready),
    .out_bit     (out_bit),
    .out_valid   (out_valid),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected per-cycle record is {out_valid, out_bit, done, ready}, starting at T+1
  task automatic run_tx(input string name, input logic [3:0] pat, input logic use_def,
                        input int rep, input int gap, input bit poke_mid,
                        input bit poke_done, output int hits);
    logic [3:0] exp_q[$];
    logic [3:0] eff;
    logic [3:0] obs;
    logic [3:0] hist;
    int         nbits;
    eff   = use_def ? 4'b1101 : pat;
    hits  = 0;
    hist  = 4'b0000;
    nbits = 0;
    for (int r = 0; r < rep; r++) begin
      for (int i = 3; i >= 0; i--) exp_q.push_back({1'b1, eff[i], 2'b00});
      if (r < rep - 1) for (int g = 0; g < gap; g++) exp_q.push_back(4'b0000);
    end
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);

    @(negedge clk);
    n_tests++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready-before-start: got %b want 1", name, ready);
    end
    start       = 1'b1;
    use_default = use_def;
    pattern_in  = pat;
    rep_cnt     = 8'(rep);
    gap_cnt     = 4'(gap);
    @(posedge clk);
    #1;
    start       = 1'b0;
    pattern_in  = 4'($urandom);
    rep_cnt     = 8'($urandom);
    gap_cnt     = 4'($urandom);
    use_default = ~use_def;

    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      obs = {out_valid, out_bit, done, ready};
      n_tests++;
      if (obs !== exp_q[k]) begin
        n_fail++;
        $display("FAIL %s cycle T+%0d {valid,bit,done,ready}: got %b want %b",
                 name, k + 1, obs, exp_q[k]);
      end
      if (out_valid === 1'b1) begin
        hist = {hist[2:0], out_bit};
        nbits++;
        if (nbits >= 4 && hist == 4'b1101) hits++;
      end
      if (poke_mid && k == 1) begin
        start      = 1'b1;
        pattern_in = ~eff;
        rep_cnt    = 8'd9;
      end else if (poke_done && exp_q[k] == 4'b0010) begin
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({ready, out_valid, out_bit, done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset-state {ready,valid,bit,done}: got %b want 1000",
               {ready, out_valid, out_bit, done});
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({ready, out_valid, out_bit, done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL post-reset-idle {ready,valid,bit,done}: got %b want 1000",
               {ready, out_valid, out_bit, done});
    end
  endtask

  task automatic test_default_single();
    int hits;
    run_tx("default_x1", 4'b0000, 1'b1, 1, 0, 1'b0, 1'b0, hits);
    n_tests++;
    if (hits !== 1) begin
      n_fail++;
      $display("FAIL default_x1 detector-hits: got %0d want 1", hits);
    end
  endtask

  task automatic test_gap();
    int hits;
    run_tx("pat1010_x3_gap2", 4'b1010, 1'b0, 3, 2, 1'b0, 1'b0, hits);
  endtask

  task automatic test_back_to_back();
    int hits;
    run_tx("default_x2_b2b", 4'b0110, 1'b1, 2, 0, 1'b0, 1'b0, hits);
    n_tests++;
    if (hits !== 2) begin
      n_fail++;
      $display("FAIL default_x2_b2b detector-hits: got %0d want 2", hits);
    end
  endtask

  task automatic test_zero_rep();
    int hits;
    run_tx("zero_rep", 4'b1111, 1'b0, 0, 3, 1'b0, 1'b0, hits);
  endtask

  task automatic test_ignore_start();
    int hits;
    run_tx("mid_start_ignored", 4'b1001, 1'b0, 2, 1, 1'b1, 1'b0, hits);
    run_tx("start_in_done_ignored", 4'b0111, 1'b0, 1, 0, 1'b0, 1'b1, hits);
  endtask

  task automatic test_async_reset();
    int hits;
    @(negedge clk);
    start       = 1'b1;
    use_default = 1'b1;
    rep_cnt     = 8'd4;
    gap_cnt     = 4'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({ready, out_valid, out_bit, done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL async-reset-immediate {ready,valid,bit,done}: got %b want 1000",
               {ready, out_valid, out_bit, done});
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL async-reset-no-done: got %b want 0", done);
    end
    rst = 1'b1;
    run_tx("after_async_reset", 4'b0000, 1'b1, 1, 0, 1'b0, 1'b0, hits);
  endtask

  task automatic test_random();
    int hits;
    for (int n = 0; n < 8; n++) begin
      run_tx("random", 4'($urandom), 1'($urandom), int'($urandom_range(0, 5)),
             int'($urandom_range(0, 3)), 1'($urandom), 1'b0, hits);
    end
  endtask

  task automatic test_max_counts();
    int hits;
    run_tx("max_rep_max_gap", 4'($urandom), 1'b0, 255, 15, 1'b0, 1'b0, hits);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b0;
    start       = 1'b0;
    use_default = 1'b0;
    pattern_in  = 4'd0;
    rep_cnt     = 8'd0;
    gap_cnt     = 4'd0;
    test_reset();
    test_default_single();
    test_gap();
    test_back_to_back();
    test_zero_rep();
    test_ignore_start();
    test_async_reset();
    test_random();
    test_max_counts();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Serial bit-stream generator; the transmit side of the team's serial sequence-detect path.
- Loads a parallel pattern and shifts it out MSB-first, one bit per clock, repeated a programmable number of times with a programmable idle gap between repetitions.
- Drives the single-bit input of downstream sequence detectors (default pattern 1101) and serves as their stimulus source in system test.

Parameters:
- PAT_W, 4, pattern width in bits (legal range 2..16).
- DEF_PAT, 4'b1101, pattern used when use_default=1; width PAT_W.
- REP_W, 8, width of repetition count.
- GAP_W, 4, width of inter-repetition gap count.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request to begin a transmission; accepted only when ready=1.
- use_default  in  1  sampled with start; 1 selects DEF_PAT, 0 selects pattern_in.
- pattern_in  in  PAT_W  pattern to send, sampled with start.
- rep_cnt  in  REP_W  number of repetitions, sampled with start; 0 = send nothing.
- gap_cnt  in  GAP_W  idle cycles between repetitions, sampled with start.
- ready  out  1  block idle and able to accept start.
- out_bit  out  1  serial data, MSB of pattern first.
- out_valid  out  1  out_bit carries a pattern bit this cycle.
- done  out  1  one-cycle pulse after the final bit of a transmission.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, ready=1, out_bit=0, out_valid=0, done=0, and all internal counters and shift register cleared. Reset asserted mid-transmission aborts immediately. No done pulse is produced. After release the block is in IDLE.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - ready=1, out_valid=0, out_bit=0.
  - start=1 at edge T latches the pattern (selected by use_default), rep_cnt and gap_cnt, and sets ready=0.
  - If rep_cnt=0: go to DONE (done=1 in cycle T+1; no bits sent).
  - Otherwise go to SHIFT; the first bit is valid in cycle T+1.
- SHIFT:
  - out_valid=1 and out_bit = current MSB of the shift register.
  - The register shifts left each cycle; a bit counter runs PAT_W-1 down to 0.
  - After the last bit of a repetition, the remaining-repetition count decrements:
    - remaining > 0 and gap_cnt = 0: reload pattern, stay in SHIFT; the next repetition follows back-to-back.
    - remaining > 0 and gap_cnt > 0: go to GAP.
    - remaining = 0: go to DONE.
- GAP:
  - out_valid=0, out_bit=0 for exactly gap_cnt cycles.
  - Then reload pattern and go to SHIFT.
- DONE:
  - done=1 for one cycle, out_valid=0, ready=0.
  - Next state IDLE; ready=1 from the following cycle.
- Latency and cycle counts:
  - Start accepted at T gives the first bit at T+1.
  - Total busy cycles = rep_cnt*PAT_W + (rep_cnt-1)*gap_cnt + 1 (DONE).
- start while ready=0 is ignored (no queuing). pattern_in, rep_cnt and gap_cnt changing mid-transmission have no effect.
- start in the same cycle that DONE returns to IDLE is ignored, because ready is still 0. start is accepted from the first cycle with ready=1.
- Counter widths are exact. rep_cnt = 2^REP_W-1 and gap_cnt = 2^GAP_W-1 must work without wrap.

Decomposition:
- Package serial_pattern_pkg holds:
  - the state enum (IDLE, SHIFT, GAP, DONE);
  - default PAT_W, DEF_PAT=4'b1101, REP_W and GAP_W constants.
- One sub-module, pattern_shift_reg (PAT_W wide), provides parallel load, shift-left and MSB output plus a bit-index counter and last-bit flag.
- The top level holds the FSM, repetition counter and gap counter.

Test Plan:
- Reset then start, use_default=1, rep_cnt=1, gap_cnt=0 -> out_bit 1,1,0,1 with out_valid=1 in cycles T+1..T+4; done=1 at T+5; ready=1 at T+6. A downstream 1101 detector fires once.
- pattern_in=4'b1010, use_default=0, rep_cnt=3, gap_cnt=2 -> stream 1010,--,1010,--,1010, where "--" is out_valid=0 for 2 cycles; done at T+17.
- rep_cnt=2, gap_cnt=0, default pattern -> 8 contiguous valid bits 11011101; detector fires twice.
- rep_cnt=0 with start -> no valid bits; done=1 at T+1; ready=1 at T+2.
- Second start pulse mid-transmission with a different pattern_in -> ignored; the output stream is unchanged.
- rst driven low asynchronously mid-SHIFT (between edges) -> out_valid, out_bit and done go 0 and ready goes 1 immediately; no done pulse. A new start after release transmits correctly from its first bit.
